// File: rtl/mips_pkg.sv
// Shared MIPS pipeline constants: instruction-memory window, NOP encoding and
// the fetch-stage state encoding.
package mips_pkg;

    localparam logic [31:0] NOP_INSTR  = 32'h0000_0000;
    localparam logic [31:0] IMEM_START = 32'h0040_0000;
    localparam int unsigned IMEM_BYTES = 1024;

    typedef enum logic {
        RUN  = 1'b0,
        HALT = 1'b1
    } fetch_state_t;

endpackage

// File: rtl/instr_fetch_if.sv
// Instruction-memory read port between the fetch stage (master) and memory (slave).
interface instr_fetch_if;

    // No valid/ready pair here: the master drives imem_addr every cycle, and the
    // slave returns the big-endian word at that address combinationally in the
    // same cycle. Every cycle is an implicit request.
    logic [31:0] imem_addr;
    logic [31:0] imem_instr;

    modport master (output imem_addr, input imem_instr);
    modport slave  (input imem_addr, output imem_instr);

endinterface

// File: rtl/fetch_addr_check.sv
// Combinational check that a word address is aligned and lies inside
// [START, START+BYTES-4]; shared by instruction and data requesters.
module fetch_addr_check #(
    parameter logic [31:0] START = 32'h0040_0000,
    parameter int unsigned BYTES = 1024
) (
    input  logic [31:0] addr,
    output logic        addr_ok
);

    // 33-bit compares so a window near the top of the address space cannot wrap.
    logic [32:0] lo;
    logic [32:0] hi;
    logic [32:0] addr_ext;

    assign lo       = {1'b0, START};
    assign hi       = {1'b0, START} + 33'(BYTES) - 33'd4;
    assign addr_ext = {1'b0, addr};

    assign addr_ok = (addr[1:0] == 2'b00) && (addr_ext >= lo) && (addr_ext <= hi);

endmodule

// File: rtl/instr_fetch.sv
// IF stage: owns the PC, fetches from instruction memory and fills the IF/ID
// register, handling stall, redirect and faulting fetches.
module instr_fetch
    import mips_pkg::*;
#(
    parameter int unsigned BYTES = IMEM_BYTES,
    parameter logic [31:0] START = IMEM_START
) (
    input  logic                 clk,
    input  logic                 rst,
    instr_fetch_if.master        imem,
    input  logic                 stall,
    input  logic                 redirect_valid,
    input  logic [31:0]          redirect_target,
    output logic                 if_id_valid,
    output logic [31:0]          if_id_instr,
    output logic [31:0]          if_id_pc_plus4,
    output logic                 if_id_fault,
    output logic [31:0]          fetch_count,
    output fetch_state_t         state_dbg
);

    fetch_state_t state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    logic         valid_q, valid_d;
    logic [31:0]  instr_q, instr_d;
    logic [31:0]  pc4_q, pc4_d;
    logic         fault_q, fault_d;
    logic [31:0]  count_q, count_d;
    logic         addr_ok;

    fetch_addr_check #(
        .START (START),
        .BYTES (BYTES)
    ) u_addr_check (
        .addr    (pc_q),
        .addr_ok (addr_ok)
    );

    assign imem.imem_addr = pc_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= RUN;
            pc_q    <= START;
            valid_q <= 1'b0;
            instr_q <= NOP_INSTR;
            pc4_q   <= 32'h0;
            fault_q <= 1'b0;
            count_q <= 32'h0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            valid_q <= valid_d;
            instr_q <= instr_d;
            pc4_q   <= pc4_d;
            fault_q <= fault_d;
            count_q <= count_d;
        end
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        valid_d = valid_q;
        instr_d = instr_q;
        pc4_d   = pc4_q;
        fault_d = fault_q;
        count_d = count_q;

        if (redirect_valid) begin
            state_d = RUN;
            pc_d    = redirect_target;
            valid_d = 1'b0;
            instr_d = NOP_INSTR;
            pc4_d   = 32'h0;
            fault_d = 1'b0;
        end else if (!stall) begin
            unique case (state_q)
                RUN: begin
                    valid_d = 1'b1;
                    pc4_d   = pc_q + 32'd4;
                    count_d = count_q + 32'd1;
                    if (addr_ok) begin
                        instr_d = imem.imem_instr;
                        fault_d = 1'b0;
                        pc_d    = pc_q + 32'd4;
                    end else begin
                        // One fault slot, then park until redirected.
                        instr_d = NOP_INSTR;
                        fault_d = 1'b1;
                        state_d = HALT;
                    end
                end
                HALT: begin
                    valid_d = 1'b0;
                    instr_d = NOP_INSTR;
                    pc4_d   = 32'h0;
                    fault_d = 1'b0;
                end
                default: state_d = RUN;
            endcase
        end
    end

    assign if_id_valid    = valid_q;
    assign if_id_instr    = instr_q;
    assign if_id_pc_plus4 = pc4_q;
    assign if_id_fault    = fault_q;
    assign fetch_count    = count_q;
    assign state_dbg      = state_q;

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: directed scenarios plus randomized traffic checked
// against a rule-level model of the fetch stage.
module tb_instr_fetch;
    import mips_pkg::*;

    localparam logic [31:0] START = 32'h0040_0000;
    localparam int unsigned BYTES = 1024;
    localparam int          WORDS = BYTES / 4;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         stall = 1'b0;
    logic         redirect_valid = 1'b0;
    logic [31:0]  redirect_target = 32'h0;
    logic         if_id_valid;
    logic [31:0]  if_id_instr;
    logic [31:0]  if_id_pc_plus4;
    logic         if_id_fault;
    logic [31:0]  fetch_count;
    fetch_state_t state_dbg;

    instr_fetch_if bus ();

    instr_fetch #(.BYTES(BYTES), .START(START)) dut (
        .clk             (clk),
        .rst             (rst),
        .imem            (bus.master),
        .stall           (stall),
        .redirect_valid  (redirect_valid),
        .redirect_target (redirect_target),
        .if_id_valid     (if_id_valid),
        .if_id_instr     (if_id_instr),
        .if_id_pc_plus4  (if_id_pc_plus4),
        .if_id_fault     (if_id_fault),
        .fetch_count     (fetch_count),
        .state_dbg       (state_dbg)
    );

    always #5 clk = ~clk;

    // ---------------- memory model ----------------
    logic [31:0] mem [WORDS];

    function automatic logic [31:0] mem_word(input logic [31:0] addr);
        longint off;
        off = longint'(addr) - longint'(START);
        if (off < 0 || off >= longint'(BYTES)) return 32'hDEAD_BEEF;
        return mem[int'(off / 4)];
    endfunction

    always_comb bus.imem_instr = mem_word(bus.imem_addr);

    // ---------------- reference model ----------------
    logic [31:0] m_pc = START;
    bit          m_halted = 0;
    logic        m_valid = 0;
    logic [31:0] m_instr = 0;
    logic [31:0] m_pc4 = 0;
    logic        m_fault = 0;
    logic [31:0] m_count = 0;

    int tests_run = 0;
    int tests_failed = 0;

    task automatic tick(input logic s, input logic rv, input logic [31:0] rt, input logic r);
        logic [31:0] n_pc, n_instr, n_pc4, n_count;
        logic        n_valid, n_fault;
        bit          n_halted;
        longint      p;
        bit          ok;
        stall = s; redirect_valid = rv; redirect_target = rt; rst = r;
        n_pc = m_pc; n_halted = m_halted; n_valid = m_valid; n_instr = m_instr;
        n_pc4 = m_pc4; n_fault = m_fault; n_count = m_count;
        p  = longint'(m_pc);
        ok = (p % 4 == 0) && p >= longint'(START) && p <= longint'(START) + BYTES - 4;
        if (r) begin
            n_pc = START; n_halted = 0; n_valid = 0; n_instr = 0; n_pc4 = 0;
            n_fault = 0; n_count = 0;
        end else if (rv) begin
            n_pc = rt; n_halted = 0; n_valid = 0; n_instr = 0; n_pc4 = 0; n_fault = 0;
        end else if (s) begin
            // everything holds
        end else if (m_halted) begin
            n_valid = 0; n_instr = 0; n_pc4 = 0; n_fault = 0;
        end else if (ok) begin
            n_valid = 1; n_instr = mem_word(m_pc); n_pc4 = m_pc + 4; n_fault = 0;
            n_pc = m_pc + 4; n_count = m_count + 1;
        end else begin
            n_valid = 1; n_instr = 0; n_pc4 = m_pc + 4; n_fault = 1;
            n_halted = 1; n_count = m_count + 1;
        end
        @(posedge clk);
        #1;
        m_pc = n_pc; m_halted = n_halted; m_valid = n_valid; m_instr = n_instr;
        m_pc4 = n_pc4; m_fault = n_fault; m_count = n_count;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        tick(0, 0, 0, 1);
        tick(0, 0, 0, 1);
        tests_run++;
        if ({bus.imem_addr, if_id_valid, if_id_instr, if_id_pc_plus4, if_id_fault, fetch_count}
            !== {START, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0} || state_dbg !== RUN) begin
            tests_failed++;
            $display("FAIL reset: pc=%h v=%b i=%h p4=%h f=%b cnt=%0d st=%0d, want pc=%h all zero RUN",
                     bus.imem_addr, if_id_valid, if_id_instr, if_id_pc_plus4, if_id_fault,
                     fetch_count, state_dbg, START);
        end
    endtask

    task automatic test_sequential();
        for (int k = 0; k < 4; k++) begin
            tests_run++;
            if (bus.imem_addr !== START + 32'(4 * k)) begin
                tests_failed++;
                $display("FAIL seq_addr[%0d]: got %h want %h", k, bus.imem_addr, START + 32'(4 * k));
            end
            tick(0, 0, 0, 0);
            tests_run++;
            if ({if_id_valid, if_id_fault, if_id_instr, if_id_pc_plus4}
                !== {1'b1, 1'b0, 32'h2008_0001 + 32'(k), START + 32'(4 * k + 4)}) begin
                tests_failed++;
                $display("FAIL seq_ifid[%0d]: v=%b f=%b i=%h p4=%h want i=%h p4=%h", k, if_id_valid,
                         if_id_fault, if_id_instr, if_id_pc_plus4, 32'h2008_0001 + 32'(k),
                         START + 32'(4 * k + 4));
            end
        end
        tests_run++;
        if (fetch_count !== 32'd4) begin
            tests_failed++;
            $display("FAIL seq_count: got %0d want 4", fetch_count);
        end
    endtask

    task automatic test_stall();
        logic [31:0] pc_s, i_s, p4_s, c_s;
        pc_s = bus.imem_addr; i_s = if_id_instr; p4_s = if_id_pc_plus4; c_s = fetch_count;
        for (int k = 0; k < 3; k++) begin
            tick(1, 0, 0, 0);
            tests_run++;
            if ({bus.imem_addr, if_id_instr, if_id_pc_plus4, fetch_count} !== {pc_s, i_s, p4_s, c_s}) begin
                tests_failed++;
                $display("FAIL stall_hold[%0d]: pc=%h i=%h p4=%h cnt=%0d want %h %h %h %0d", k,
                         bus.imem_addr, if_id_instr, if_id_pc_plus4, fetch_count, pc_s, i_s, p4_s, c_s);
            end
        end
        tick(0, 0, 0, 0);
        tests_run++;
        if ({if_id_instr, if_id_pc_plus4, fetch_count} !== {mem_word(pc_s), pc_s + 32'd4, c_s + 32'd1}) begin
            tests_failed++;
            $display("FAIL stall_resume: i=%h p4=%h cnt=%0d want %h %h %0d", if_id_instr,
                     if_id_pc_plus4, fetch_count, mem_word(pc_s), pc_s + 32'd4, c_s + 32'd1);
        end
    endtask

    task automatic test_redirect_over_stall();
        logic [31:0] c_s;
        c_s = fetch_count;
        tick(1, 1, 32'h0040_0100, 0);
        tests_run++;
        if ({bus.imem_addr, if_id_valid, if_id_instr, fetch_count} !== {32'h0040_0100, 1'b0, 32'h0, c_s}) begin
            tests_failed++;
            $display("FAIL redirect_stall: pc=%h v=%b i=%h cnt=%0d want 00400100 0 0 %0d",
                     bus.imem_addr, if_id_valid, if_id_instr, fetch_count, c_s);
        end
        tick(0, 0, 0, 0);
        tests_run++;
        if ({if_id_valid, if_id_instr, if_id_pc_plus4} !== {1'b1, mem[64], 32'h0040_0104}) begin
            tests_failed++;
            $display("FAIL redirect_fetch: v=%b i=%h p4=%h want 1 %h 00400104", if_id_valid,
                     if_id_instr, if_id_pc_plus4, mem[64]);
        end
    endtask

    task automatic test_end_of_mem();
        tick(0, 1, START + BYTES - 16, 0);
        for (int k = 0; k < 4; k++) tick(0, 0, 0, 0);
        tests_run++;
        if ({if_id_valid, if_id_fault, if_id_instr, if_id_pc_plus4} !== {1'b1, 1'b0, mem[WORDS-1], 32'h0040_0400}) begin
            tests_failed++;
            $display("FAIL last_word: v=%b f=%b i=%h p4=%h want 1 0 %h 00400400", if_id_valid,
                     if_id_fault, if_id_instr, if_id_pc_plus4, mem[WORDS-1]);
        end
        tick(0, 0, 0, 0);
        tests_run++;
        if ({if_id_valid, if_id_fault, if_id_instr, if_id_pc_plus4} !== {1'b1, 1'b1, 32'h0, 32'h0040_0404}
            || state_dbg !== HALT) begin
            tests_failed++;
            $display("FAIL oob_fault: v=%b f=%b i=%h p4=%h st=%0d want 1 1 0 00400404 HALT", if_id_valid,
                     if_id_fault, if_id_instr, if_id_pc_plus4, state_dbg);
        end
        for (int k = 0; k < 2; k++) begin
            tick(0, 0, 0, 0);
            tests_run++;
            if ({if_id_valid, if_id_fault, if_id_instr, if_id_pc_plus4, bus.imem_addr}
                !== {1'b0, 1'b0, 32'h0, 32'h0, 32'h0040_0400}) begin
                tests_failed++;
                $display("FAIL halt_bubble[%0d]: v=%b f=%b i=%h p4=%h pc=%h want bubble pc=00400400", k,
                         if_id_valid, if_id_fault, if_id_instr, if_id_pc_plus4, bus.imem_addr);
            end
        end
    endtask

    task automatic test_misaligned();
        logic [31:0] c_s;
        tick(0, 1, 32'h0040_0002, 0);
        c_s = fetch_count;
        tick(0, 0, 0, 0);
        tests_run++;
        if ({if_id_valid, if_id_fault, if_id_instr, if_id_pc_plus4, fetch_count}
            !== {1'b1, 1'b1, 32'h0, 32'h0040_0006, c_s + 32'd1}) begin
            tests_failed++;
            $display("FAIL misalign_fault: v=%b f=%b i=%h p4=%h cnt=%0d want 1 1 0 00400006 %0d",
                     if_id_valid, if_id_fault, if_id_instr, if_id_pc_plus4, fetch_count, c_s + 32'd1);
        end
        tick(0, 0, 0, 0);
        tests_run++;
        if ({if_id_valid, if_id_fault, fetch_count} !== {1'b0, 1'b0, c_s + 32'd1} || state_dbg !== HALT) begin
            tests_failed++;
            $display("FAIL misalign_halt: v=%b f=%b cnt=%0d st=%0d want 0 0 %0d HALT", if_id_valid,
                     if_id_fault, fetch_count, state_dbg, c_s + 32'd1);
        end
        tick(0, 1, START, 0);
        tick(0, 0, 0, 0);
        tests_run++;
        if ({if_id_valid, if_id_fault, if_id_instr, bus.imem_addr} !== {1'b1, 1'b0, mem[0], START + 32'd4}
            || state_dbg !== RUN) begin
            tests_failed++;
            $display("FAIL misalign_recover: v=%b f=%b i=%h pc=%h st=%0d want 1 0 %h 00400004 RUN",
                     if_id_valid, if_id_fault, if_id_instr, bus.imem_addr, state_dbg, mem[0]);
        end
    endtask

    task automatic test_reset_in_halt();
        tick(0, 0, 0, 1);
        tick(0, 1, START + BYTES - 24, 0);
        for (int k = 0; k < 8; k++) tick(0, 0, 0, 0);
        tests_run++;
        if (fetch_count !== 32'd7 || state_dbg !== HALT) begin
            tests_failed++;
            $display("FAIL pre_reset_count: cnt=%0d st=%0d want 7 HALT", fetch_count, state_dbg);
        end
        tick(1, 0, 0, 1);
        tests_run++;
        if ({bus.imem_addr, if_id_valid, if_id_instr, if_id_pc_plus4, if_id_fault, fetch_count}
            !== {START, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0} || state_dbg !== RUN) begin
            tests_failed++;
            $display("FAIL reset_in_halt: pc=%h v=%b i=%h p4=%h f=%b cnt=%0d st=%0d want reset values",
                     bus.imem_addr, if_id_valid, if_id_instr, if_id_pc_plus4, if_id_fault,
                     fetch_count, state_dbg);
        end
    endtask

    task automatic test_random();
        logic        s, rv, r;
        logic [31:0] rt;
        int          sel;
        for (int n = 0; n < 400; n++) begin
            s  = ($urandom_range(0, 3) == 0);
            rv = ($urandom_range(0, 9) == 0);
            r  = ($urandom_range(0, 49) == 0);
            sel = $urandom_range(0, 9);
            if (sel < 6)      rt = START + 32'($urandom_range(0, WORDS - 1) * 4);
            else if (sel < 8) rt = START + BYTES - 32'($urandom_range(1, 3) * 4);
            else if (sel < 9) rt = START + 32'($urandom_range(0, BYTES - 1));
            else              rt = $urandom;
            tick(s, rv, rt, r);
            tests_run++;
            if ({bus.imem_addr, if_id_valid, if_id_instr, if_id_pc_plus4, if_id_fault, fetch_count}
                !== {m_pc, m_valid, m_instr, m_pc4, m_fault, m_count} || (state_dbg == HALT) !== m_halted) begin
                tests_failed++;
                $display("FAIL random[%0d]: pc=%h v=%b i=%h p4=%h f=%b cnt=%0d st=%0d want %h %b %h %h %b %0d %0d",
                         n, bus.imem_addr, if_id_valid, if_id_instr, if_id_pc_plus4, if_id_fault,
                         fetch_count, state_dbg, m_pc, m_valid, m_instr, m_pc4, m_fault, m_count, m_halted);
            end
        end
    endtask

    initial begin
        for (int i = 0; i < WORDS; i++)
            mem[i] = (i < 16) ? 32'h2008_0001 + 32'(i) : $urandom;
        test_reset();
        test_sequential();
        test_stall();
        test_redirect_over_stall();
        test_end_of_mem();
        test_misaligned();
        test_reset_in_halt();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
